alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

In-order issue controller between decode and the ALU. It buffers decoded ALU operations in a small FIFO and reads source operands from the register file. A 32-entry busy scoreboard holds back any operation whose source or destination register has an in-flight write. It issues at most one operation per cycle when the ALU accepts, clears scoreboard bits on write-back, and drops everything on flush.

## Interface
Parameters:
- XLEN, 32, datapath width
- QDEPTH, 2, issue FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decoded op offered
- dec_ready  out  1  FIFO can accept (= not full)
- dec_unit  in  2  unit select (0 = ALU)
- dec_sub_unit  in  3  ALU sub-unit
- dec_sel  in  4  ALU operation select
- dec_rs1_idx, dec_rs2_idx  in  5 each  source register indices
- dec_use_rs1, dec_use_rs2  in  1 each  source actually read
- dec_rd  in  5  destination index (0 = no write)
- dec_pc, dec_imm  in  XLEN each  PC and immediate
- dec_imm_sel, dec_j_instr  in  1 each  immediate-operand flag, jump flag
- rf_rs1_idx, rf_rs2_idx  out  5 each  register-file read addresses (head entry)
- rf_rs1_data, rf_rs2_data  in  XLEN each  combinational read data
- issue_valid  out  1  head op issuable this cycle
- alu_ready  in  1  ALU accepts an op this cycle
- issue_unit, issue_sub_unit, issue_sel, issue_rd, issue_pc, issue_imm, issue_imm_sel, issue_j_instr  out  as dec_*  head fields
- issue_rs1, issue_rs2  out  XLEN each  operand data (forced 0 when index is 0)
- wb_valid  in  1  write-back completing
- wb_rd  in  5  write-back destination
- flush  in  1  discard queued ops and scoreboard
- stall_cnt  out  32  cycles with a valid head that could not issue

## Operation
- FIFO: QDEPTH entries; rd/wr pointers of log2(QDEPTH)+1 bits; full = same index with MSB differing; empty = equal.
- Enqueue when dec_valid && dec_ready && !flush.
- Dequeue on issue fire: issue_valid && alu_ready.
- Enqueue and dequeue may occur in the same cycle; count is unchanged.
- dec_ready = !full, combinational. No bypass: enqueuing into a full FIFO in the same cycle it dequeues is not allowed.
- Hazard for head: (use_rs1 && rs1_idx≠0 && busy[rs1_idx]) || (use_rs2 && rs2_idx≠0 && busy[rs2_idx]) || (rd≠0 && busy[rd]). The last term blocks WAW.
- issue_valid = !empty && !hazard && !flush && dec_unit of head == 0. A head with unit≠0 is dropped silently on the next cycle (dequeued, no issue, no busy set).
- Scoreboard busy[31:1] registers; busy[0] is hard-wired 0.
- On issue fire with rd≠0: set busy[rd].
- On wb_valid: clear busy[wb_rd].
- Same-cycle set and clear of the same index: set wins, because the newer producer is in flight.
- No forwarding: a write-back clearing a head source makes the head issuable the following cycle. The register file is written on that same edge.
- flush: pointers reset to empty and all busy bits cleared. Flush overrides enqueue, issue and write-back in that cycle.
- stall_cnt increments when !empty && !issue_valid && !flush, and saturates at 0xFFFFFFFF. flush does not clear it.

## Timing
- Reset (rst high at edge):
  - FIFO empty, busy = 0, stall_cnt = 0.
  - issue_valid = 0, dec_ready = 1, and all issue_* data outputs = 0 (FIFO storage cleared).
- Latency: op enqueued at edge N is on issue_* with issue_valid in cycle N+1, if no hazard.
- Back-to-back independent ops issue every cycle; throughput is 1/cycle.
- A dependent op (RAW on the previous issue's rd) waits until the cycle after that rd's wb_valid.
- Issue outputs are combinational from head registers and the busy registers. alu_ready may depend on issue_unit but not on issue_valid.
- rst asserted mid-operation behaves as flush plus stall_cnt clear. It takes effect at the next edge.

## Test plan
- Reset then idle: rst 2 cycles -> issue_valid=0, dec_ready=1, stall_cnt=0.
- Independent pair: enqueue ADD rd=5 (rs 1,2) then ADD rd=6 (rs 3,4), alu_ready=1 -> issued in consecutive cycles, busy[5] and busy[6] set, dec_ready held 1.
- RAW stall: issue rd=5, enqueue op using rs1=5, wb_valid/wb_rd=5 three cycles later -> dependent op issues exactly one cycle after the wb cycle; stall_cnt=4.
- Full and backpressure: alu_ready=0, enqueue 3 ops with QDEPTH=2 -> dec_ready=0 after the 2nd, the 3rd is held. Raise alu_ready -> in-order issue, dec_ready=1 the cycle after the first fire.
- Set/clear collision: issue rd=7 in the same cycle wb_rd=7 -> busy[7]=1 afterwards. An x0 destination/source never sets busy or stalls.
- Flush mid-stream: 2 queued ops, busy[5]=1, flush with dec_valid=1 -> next cycle empty, busy=0, no issue, new op not enqueued.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: decode/issue/register-file/write-back bundle for alu_issue_ctrl.
//   slave  : view taken by alu_issue_ctrl (accepts decode ops, drives issue fields)
//   master : view taken by the surrounding pipeline (or a bench)
//   dec_*   decoded op offer and ready
//   rf_*    register-file read port for the head entry
//   issue_* head op toward the ALU, alu_ready handshake
//   wb_*    write-back completion that releases scoreboard bits
//   flush   discard queued ops and scoreboard; stall_cnt is the stall counter
interface alu_issue_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            dec_valid;
    logic            dec_ready;
    logic [1:0]      dec_unit;
    logic [2:0]      dec_sub_unit;
    logic [3:0]      dec_sel;
    logic [4:0]      dec_rs1_idx;
    logic [4:0]      dec_rs2_idx;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_imm;
    logic            dec_imm_sel;
    logic            dec_j_instr;

    logic [4:0]      rf_rs1_idx;
    logic [4:0]      rf_rs2_idx;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;

    logic            issue_valid;
    logic            alu_ready;
    logic [1:0]      issue_unit;
    logic [2:0]      issue_sub_unit;
    logic [3:0]      issue_sel;
    logic [4:0]      issue_rd;
    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] issue_imm;
    logic            issue_imm_sel;
    logic            issue_j_instr;
    logic [XLEN-1:0] issue_rs1;
    logic [XLEN-1:0] issue_rs2;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            flush;
    logic [31:0]     stall_cnt;

    modport slave (
        input  dec_valid, dec_unit, dec_sub_unit, dec_sel, dec_rs1_idx, dec_rs2_idx,
               dec_use_rs1, dec_use_rs2, dec_rd, dec_pc, dec_imm, dec_imm_sel, dec_j_instr,
        output dec_ready,
        output rf_rs1_idx, rf_rs2_idx,
        input  rf_rs1_data, rf_rs2_data,
        output issue_valid, issue_unit, issue_sub_unit, issue_sel, issue_rd, issue_pc,
               issue_imm, issue_imm_sel, issue_j_instr, issue_rs1, issue_rs2,
        input  alu_ready, wb_valid, wb_rd, flush,
        output stall_cnt
    );

    modport master (
        output dec_valid, dec_unit, dec_sub_unit, dec_sel, dec_rs1_idx, dec_rs2_idx,
               dec_use_rs1, dec_use_rs2, dec_rd, dec_pc, dec_imm, dec_imm_sel, dec_j_instr,
        input  dec_ready,
        input  rf_rs1_idx, rf_rs2_idx,
        output rf_rs1_data, rf_rs2_data,
        input  issue_valid, issue_unit, issue_sub_unit, issue_sel, issue_rd, issue_pc,
               issue_imm, issue_imm_sel, issue_j_instr, issue_rs1, issue_rs2,
        output alu_ready, wb_valid, wb_rd, flush,
        input  stall_cnt
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: in-order ALU issue stage with a small op FIFO and a
// 32-entry busy scoreboard (RAW and WAW interlock, no forwarding).
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (flush plus stall counter clear)
//   bus  : alu_issue_ctrl_if.slave (decode in, issue out, rf read, write-back, flush)
module alu_issue_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);
    localparam int unsigned AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned NREG = 32;

    typedef struct packed {
        logic [1:0]      unit;
        logic [2:0]      sub_unit;
        logic [3:0]      sel;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic            use_rs1;
        logic            use_rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic            j_instr;
    } entry_t;

    entry_t          mem_q [QDEPTH];
    entry_t          dec_entry_c;
    entry_t          head_c;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [31:0]     stall_q, stall_d;

    logic empty_c, full_c, hazard_c, valid_c, fire_c, drop_c, enq_c, deq_c;

    assign dec_entry_c = '{
        unit:     bus.dec_unit,
        sub_unit: bus.dec_sub_unit,
        sel:      bus.dec_sel,
        rs1_idx:  bus.dec_rs1_idx,
        rs2_idx:  bus.dec_rs2_idx,
        use_rs1:  bus.dec_use_rs1,
        use_rs2:  bus.dec_use_rs2,
        rd:       bus.dec_rd,
        pc:       bus.dec_pc,
        imm:      bus.dec_imm,
        imm_sel:  bus.dec_imm_sel,
        j_instr:  bus.dec_j_instr
    };

    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_c = (rd_ptr_q == wr_ptr_q);
    assign full_c  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[PW-1] != wr_ptr_q[PW-1]);

    // Last term holds the head while an older write to the same rd is in flight (WAW).
    assign hazard_c = (head_c.use_rs1 && (head_c.rs1_idx != 5'd0) && busy_q[head_c.rs1_idx])
                   || (head_c.use_rs2 && (head_c.rs2_idx != 5'd0) && busy_q[head_c.rs2_idx])
                   || ((head_c.rd != 5'd0) && busy_q[head_c.rd]);

    assign valid_c = !empty_c && !hazard_c && !bus.flush && (head_c.unit == 2'd0);
    assign fire_c  = valid_c && bus.alu_ready;
    // Non-ALU ops are discarded from the head without touching the scoreboard.
    assign drop_c  = !empty_c && !bus.flush && (head_c.unit != 2'd0);
    assign enq_c   = bus.dec_valid && !full_c && !bus.flush;
    assign deq_c   = fire_c || drop_c;

    // Next-state: pointers, scoreboard (set beats clear), saturating stall counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        busy_d   = busy_q;
        stall_d  = stall_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            busy_d   = '0;
        end else begin
            if (enq_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq_c) rd_ptr_d = rd_ptr_q + PW'(1);
            if (bus.wb_valid) busy_d[bus.wb_rd] = 1'b0;
            if (fire_c && (head_c.rd != 5'd0)) busy_d[head_c.rd] = 1'b1;
            if (!empty_c && !valid_c && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
        end
    end

    // Entry storage; cleared on reset so the idle head presents all-zero fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
        end else if (enq_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dec_entry_c;
        end
    end

    assign bus.dec_ready      = !full_c;
    assign bus.rf_rs1_idx     = head_c.rs1_idx;
    assign bus.rf_rs2_idx     = head_c.rs2_idx;
    assign bus.issue_valid    = valid_c;
    assign bus.issue_unit     = head_c.unit;
    assign bus.issue_sub_unit = head_c.sub_unit;
    assign bus.issue_sel      = head_c.sel;
    assign bus.issue_rd       = head_c.rd;
    assign bus.issue_pc       = head_c.pc;
    assign bus.issue_imm      = head_c.imm;
    assign bus.issue_imm_sel  = head_c.imm_sel;
    assign bus.issue_j_instr  = head_c.j_instr;
    assign bus.issue_rs1      = (head_c.rs1_idx == 5'd0) ? '0 : bus.rf_rs1_data;
    assign bus.issue_rs2      = (head_c.rs2_idx == 5'd0) ? '0 : bus.rf_rs2_data;
    assign bus.stall_cnt      = stall_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl (XLEN=32, QDEPTH=2).
module tb_alu_issue_ctrl;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned QDEPTH = 2;
    localparam logic [31:0] RF1 = 32'hA500_0000;
    localparam logic [31:0] RF2 = 32'h5A00_0000;

    typedef struct {
        logic [1:0]  unit;
        logic [2:0]  sub;
        logic [3:0]  sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        imm_sel;
        logic        j;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_fire = 0;
    int   prev_fire = 0;
    op_t  exp_q [$];

    alu_issue_ctrl_if #(.XLEN(XLEN)) bus ();

    alu_issue_ctrl #(.XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: data is a fixed pattern of the read address.
    assign bus.rf_rs1_data = RF1 ^ 32'(bus.rf_rs1_idx);
    assign bus.rf_rs2_data = RF2 ^ 32'(bus.rf_rs2_idx);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [1:0] unit);
        op_t o;
        o.unit    = unit;
        o.sub     = 3'(rd + 5'd1);
        o.sel     = 4'(rd ^ rs1);
        o.rs1     = rs1;
        o.rs2     = rs2;
        o.use1    = u1;
        o.use2    = u2;
        o.rd      = rd;
        o.pc      = 32'h0000_1000 + 32'(rd) * 32'd4;
        o.imm     = $urandom;
        o.imm_sel = rd[0];
        o.j       = rd[1];
        return o;
    endfunction

    task automatic drive(input op_t o);
        bus.dec_valid    = 1'b1;
        bus.dec_unit     = o.unit;
        bus.dec_sub_unit = o.sub;
        bus.dec_sel      = o.sel;
        bus.dec_rs1_idx  = o.rs1;
        bus.dec_rs2_idx  = o.rs2;
        bus.dec_use_rs1  = o.use1;
        bus.dec_use_rs2  = o.use2;
        bus.dec_rd       = o.rd;
        bus.dec_pc       = o.pc;
        bus.dec_imm      = o.imm;
        bus.dec_imm_sel  = o.imm_sel;
        bus.dec_j_instr  = o.j;
    endtask

    task automatic idle();
        drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0));
        bus.dec_valid = 1'b0;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    // Samples after the monitor has run on the same falling edge.
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        wait_edge();
        rst = 1'b1;
        idle();
        wb(1'b0, 5'd0);
        bus.flush     = 1'b0;
        bus.alu_ready = 1'b0;
        wait_edge();
        wait_edge();
        rst = 1'b0;
        exp_q.delete();
        sample();
        chk({tag, "_rst_iv"},   64'(bus.issue_valid), 64'd0);
        chk({tag, "_rst_rdy"},  64'(bus.dec_ready),   64'd1);
        chk({tag, "_rst_stl"},  64'(bus.stall_cnt),   64'd0);
        chk({tag, "_rst_pc"},   64'(bus.issue_pc),    64'd0);
        chk({tag, "_rst_rs1"},  64'(bus.issue_rs1),   64'd0);
    endtask

    // Scoreboard: accepted ALU ops are queued; every fire must match the oldest one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.issue_valid && bus.alu_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_fire", 64'd1, 64'd0);
                end else begin
                    op_t e;
                    e = exp_q.pop_front();
                    chk("iss_unit", 64'(bus.issue_unit),     64'(e.unit));
                    chk("iss_sub",  64'(bus.issue_sub_unit), 64'(e.sub));
                    chk("iss_sel",  64'(bus.issue_sel),      64'(e.sel));
                    chk("iss_rd",   64'(bus.issue_rd),       64'(e.rd));
                    chk("iss_pc",   64'(bus.issue_pc),       64'(e.pc));
                    chk("iss_imm",  64'(bus.issue_imm),      64'(e.imm));
                    chk("iss_isel", 64'(bus.issue_imm_sel),  64'(e.imm_sel));
                    chk("iss_j",    64'(bus.issue_j_instr),  64'(e.j));
                    chk("iss_rs1",  64'(bus.issue_rs1), (e.rs1 == 5'd0) ? 64'd0 : 64'(RF1 ^ 32'(e.rs1)));
                    chk("iss_rs2",  64'(bus.issue_rs2), (e.rs2 == 5'd0) ? 64'd0 : 64'(RF2 ^ 32'(e.rs2)));
                    prev_fire = last_fire;
                    last_fire = cyc;
                end
            end
            if (bus.dec_valid && bus.dec_ready && !bus.flush && (bus.dec_unit == 2'd0)) begin
                op_t n;
                n.unit = bus.dec_unit;       n.sub  = bus.dec_sub_unit; n.sel = bus.dec_sel;
                n.rs1  = bus.dec_rs1_idx;    n.rs2  = bus.dec_rs2_idx;
                n.use1 = bus.dec_use_rs1;    n.use2 = bus.dec_use_rs2;  n.rd  = bus.dec_rd;
                n.pc   = bus.dec_pc;         n.imm  = bus.dec_imm;
                n.imm_sel = bus.dec_imm_sel; n.j    = bus.dec_j_instr;
                exp_q.push_back(n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        wb(1'b0, 5'd0);
        bus.flush     = 1'b0;
        bus.alu_ready = 1'b0;

        // Independent pair, then an op waiting on both rds, then an x0-only op.
        do_reset("t2");
        wait_edge(); bus.alu_ready = 1'b1; drive(mk(5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0));
        sample();    chk("t2_rdy_a", 64'(bus.dec_ready), 64'd1);
        wait_edge(); drive(mk(5'd6, 5'd3, 1'b1, 5'd4, 1'b1, 2'd0));
        sample();    chk("t2_iv_a", 64'(bus.issue_valid), 64'd1);
                     chk("t2_rdy_b", 64'(bus.dec_ready), 64'd1);
        wait_edge(); drive(mk(5'd0, 5'd5, 1'b1, 5'd6, 1'b1, 2'd0));
        sample();    chk("t2_iv_b", 64'(bus.issue_valid), 64'd1);
                     chk("t2_b2b", 64'(last_fire - prev_fire), 64'd1);
        wait_edge(); idle();
        sample();    chk("t2_busy56", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b1, 5'd5);
        sample();    chk("t2_wb5", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b0, 5'd0);
        sample();    chk("t2_busy6", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b1, 5'd6);
        sample();    chk("t2_wb6", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b0, 5'd0);
        sample();    chk("t2_iv_c", 64'(bus.issue_valid), 64'd1);
        wait_edge(); drive(mk(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0)); wb(1'b1, 5'd0);
        sample();    chk("t2_empty", 64'(bus.issue_valid), 64'd0);
        wait_edge(); idle(); wb(1'b0, 5'd0);
        sample();    chk("t2_x0_iv", 64'(bus.issue_valid), 64'd1);
                     chk("t2_stall", 64'(bus.stall_cnt), 64'd4);

        // RAW: dependent op issues the cycle after the write-back cycle.
        do_reset("t3");
        wait_edge(); bus.alu_ready = 1'b1; drive(mk(5'd5, 5'd1, 1'b1, 5'd2, 1'b0, 2'd0));
        sample();
        wait_edge(); drive(mk(5'd9, 5'd5, 1'b1, 5'd3, 1'b1, 2'd0));
        sample();    chk("t3_iv_a", 64'(bus.issue_valid), 64'd1);
        wait_edge(); idle();
        sample();    chk("t3_st1", 64'(bus.issue_valid), 64'd0);
        wait_edge();
        sample();    chk("t3_st2", 64'(bus.issue_valid), 64'd0);
        wait_edge();
        sample();    chk("t3_st3", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b1, 5'd5);
        sample();    chk("t3_st4", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b0, 5'd0);
        sample();    chk("t3_iv_b", 64'(bus.issue_valid), 64'd1);
                     chk("t3_stall", 64'(bus.stall_cnt), 64'd4);

        // Full FIFO and backpressure.
        do_reset("t4");
        wait_edge(); drive(mk(5'd10, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0));
        sample();    chk("t4_rdy1", 64'(bus.dec_ready), 64'd1);
        wait_edge(); drive(mk(5'd11, 5'd2, 1'b1, 5'd3, 1'b1, 2'd0));
        sample();    chk("t4_rdy2", 64'(bus.dec_ready), 64'd1);
                     chk("t4_iv1", 64'(bus.issue_valid), 64'd1);
        wait_edge(); drive(mk(5'd12, 5'd3, 1'b1, 5'd4, 1'b0, 2'd0));
        sample();    chk("t4_full", 64'(bus.dec_ready), 64'd0);
        wait_edge();
        sample();    chk("t4_held", 64'(bus.dec_ready), 64'd0);
        wait_edge(); bus.alu_ready = 1'b1;
        sample();    chk("t4_full_fire", 64'(bus.dec_ready), 64'd0);
        wait_edge();
        sample();    chk("t4_rdy_after", 64'(bus.dec_ready), 64'd1);
        wait_edge(); idle();
        sample();    chk("t4_iv3", 64'(bus.issue_valid), 64'd1);
        wait_edge();
        sample();    chk("t4_drain_iv", 64'(bus.issue_valid), 64'd0);
                     chk("t4_drain_rdy", 64'(bus.dec_ready), 64'd1);
                     chk("t4_stall", 64'(bus.stall_cnt), 64'd0);

        // Same-cycle set and clear of rd=7: set wins.
        do_reset("t5");
        wait_edge(); bus.alu_ready = 1'b1; drive(mk(5'd7, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0));
        sample();
        wait_edge(); drive(mk(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 2'd0)); wb(1'b1, 5'd7);
        sample();    chk("t5_iv_x", 64'(bus.issue_valid), 64'd1);
        wait_edge(); idle(); wb(1'b0, 5'd0);
        sample();    chk("t5_set_wins", 64'(bus.issue_valid), 64'd0);
        wait_edge();
        sample();    chk("t5_hold", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b1, 5'd7);
        sample();    chk("t5_wb7", 64'(bus.issue_valid), 64'd0);
        wait_edge(); wb(1'b0, 5'd0);
        sample();    chk("t5_iv_y", 64'(bus.issue_valid), 64'd1);
                     chk("t5_stall", 64'(bus.stall_cnt), 64'd3);

        // Non-ALU head is dropped and never sets busy.
        do_reset("t7");
        wait_edge(); bus.alu_ready = 1'b1; drive(mk(5'd8, 5'd1, 1'b1, 5'd2, 1'b1, 2'd2));
        sample();
        wait_edge(); drive(mk(5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 2'd0));
        sample();    chk("t7_unit_iv", 64'(bus.issue_valid), 64'd0);
        wait_edge(); idle();
        sample();    chk("t7_iv_v", 64'(bus.issue_valid), 64'd1);
                     chk("t7_stall", 64'(bus.stall_cnt), 64'd1);

        // Flush with two queued ops and busy[5] set.
        do_reset("t6");
        wait_edge(); bus.alu_ready = 1'b1; drive(mk(5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0));
        sample();
        wait_edge(); drive(mk(5'd10, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0));
        sample();    chk("t6_iv_p", 64'(bus.issue_valid), 64'd1);
        wait_edge(); bus.alu_ready = 1'b0; drive(mk(5'd11, 5'd3, 1'b1, 5'd4, 1'b1, 2'd0));
        sample();
        wait_edge(); drive(mk(5'd12, 5'd1, 1'b1, 5'd2, 1'b1, 2'd0)); bus.flush = 1'b1;
        sample();    chk("t6_flush_iv", 64'(bus.issue_valid), 64'd0);
        exp_q.delete();
        wait_edge(); idle(); bus.flush = 1'b0;
        sample();    chk("t6_post_iv", 64'(bus.issue_valid), 64'd0);
                     chk("t6_post_rdy", 64'(bus.dec_ready), 64'd1);
                     chk("t6_stall", 64'(bus.stall_cnt), 64'd0);
        wait_edge(); bus.alu_ready = 1'b1; drive(mk(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 2'd0));
        sample();
        wait_edge(); idle();
        sample();    chk("t6_busy_clr", 64'(bus.issue_valid), 64'd1);

        wait_edge(); idle(); bus.alu_ready = 1'b0;
        sample();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
